load_sequencer: RTL and testbench

Multi-cycle sequencer that runs one memory load (lw/lh/lb) end to end for the control unit. It issues the memory read, strobes the MDR, drives the CT select of the downstream LoadMask, captures the masked word and writes it back to the register file. It sits between the main control FSM, the data memory/MDR and LoadMask, so the control unit only raises one request per load instruction.

---
 rtl/load_sequencer.sv | 134 +++++++++++++
 tb/tb_load_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_sequencer.sv
// Runs one lw/lh/lb end to end: memory read, MDR strobe, LoadMask select,
// masked-word capture and register-file write-back, all from a single request.
module load_sequencer #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mdr_load,
  output logic [1:0]  mask_ct,
  input  logic [31:0] mask_out,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TYPE_W = 2;
  localparam logic [CNT_W-1:0]  CNT_LOAD     = CNT_W'(MEM_LAT - 1);
  localparam logic [TYPE_W-1:0] TYPE_ILLEGAL = TYPE_W'(3);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    MASK,
    WB
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             capture;
  logic             mem_rd_d;
  logic             mdr_load_d;
  logic             wb_en_d;
  logic             err_d;
  logic             busy_d;
  logic             req_ready_d;

  // Next-state logic; outputs are decoded from the next state so they
  // appear registered yet line up with the state they belong to.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_type == TYPE_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            capture = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt == '0) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      LATCH:   state_d = MASK;
      MASK:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_rd_d    = (state_d == READ);
    mdr_load_d  = (state_d == LATCH);
    wb_en_d     = (state_d == WB);
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_rd    <= 1'b0;
      mdr_load  <= 1'b0;
      wb_en     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mem_rd    <= mem_rd_d;
      mdr_load  <= mdr_load_d;
      wb_en     <= wb_en_d;
      done      <= wb_en_d;
      err       <= err_d;
      busy      <= busy_d;
      req_ready <= req_ready_d;
    end
  end

  // Request fields stay held until the next legal accept; the masked word
  // is taken at the end of MASK, after the MDR has settled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr <= '0;
      mask_ct  <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      if (capture) begin
        mem_addr <= req_addr;
        mask_ct  <= req_type;
        wb_rd    <= req_rd;
      end
      if (state == MASK) begin
        wb_data <= mask_out;
      end
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: two instances (MEM_LAT 1 and 3), each
// with its own memory, MDR and LoadMask model.
module tb_load_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_type  = 2'd0;
  logic [31:0] req_addr  = 32'd0;
  logic [4:0]  req_rd    = 5'd0;

  logic        req_ready_1, mem_rd_1, mdr_load_1, wb_en_1, done_1, err_1, busy_1;
  logic [31:0] mem_addr_1, mask_out_1, wb_data_1, mem_data_1;
  logic [31:0] mdr_1 = 32'd0;
  logic [1:0]  mask_ct_1;
  logic [4:0]  wb_rd_1;
  logic [6:0]  ctrl_1;

  logic        req_ready_3, mem_rd_3, mdr_load_3, wb_en_3, done_3, err_3, busy_3;
  logic [31:0] mem_addr_3, mask_out_3, wb_data_3, mem_data_3;
  logic [31:0] mdr_3 = 32'd0;
  logic [1:0]  mask_ct_3;
  logic [4:0]  wb_rd_3;
  logic [6:0]  ctrl_3;

  int checks     = 0;
  int failures   = 0;
  int rdcnt_1    = 0;
  int rdcnt_3    = 0;
  int done_cnt_1 = 0;
  int done_cnt_3 = 0;
  int exp_done_1 = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h8001F0F5 : ~a;
  endfunction

  function automatic logic [31:0] load_mask(input logic [31:0] d, input logic [1:0] ct);
    case (ct)
      2'd1:    return {16'h0000, d[15:0]};
      2'd2:    return {24'h000000, d[7:0]};
      default: return d;
    endcase
  endfunction

  // Data is only valid once mem_rd has been held for the instance's latency.
  assign mem_data_1 = (rdcnt_1 >= 1) ? mem_word(mem_addr_1) : 32'hDEADBEEF;
  assign mem_data_3 = (rdcnt_3 >= 3) ? mem_word(mem_addr_3) : 32'hDEADBEEF;
  assign mask_out_1 = load_mask(mdr_1, mask_ct_1);
  assign mask_out_3 = load_mask(mdr_3, mask_ct_3);
  assign ctrl_1 = {mem_rd_1, mdr_load_1, wb_en_1, done_1, err_1, busy_1, req_ready_1};
  assign ctrl_3 = {mem_rd_3, mdr_load_3, wb_en_3, done_3, err_3, busy_3, req_ready_3};

  always @(posedge clk) begin
    if (mem_rd_1) rdcnt_1 <= rdcnt_1 + 1;
    else if (!mdr_load_1) rdcnt_1 <= 0;
    if (mem_rd_3) rdcnt_3 <= rdcnt_3 + 1;
    else if (!mdr_load_3) rdcnt_3 <= 0;
    if (mdr_load_1) mdr_1 <= mem_data_1;
    if (mdr_load_3) mdr_3 <= mem_data_3;
    if (done_1) done_cnt_1 <= done_cnt_1 + 1;
    if (done_3) done_cnt_3 <= done_cnt_3 + 1;
  end

  load_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_1),
    .req_type(req_type), .req_addr(req_addr), .req_rd(req_rd),
    .mem_addr(mem_addr_1), .mem_rd(mem_rd_1), .mdr_load(mdr_load_1),
    .mask_ct(mask_ct_1), .mask_out(mask_out_1), .wb_en(wb_en_1), .wb_rd(wb_rd_1),
    .wb_data(wb_data_1), .done(done_1), .err(err_1), .busy(busy_1)
  );

  load_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_3),
    .req_type(req_type), .req_addr(req_addr), .req_rd(req_rd),
    .mem_addr(mem_addr_3), .mem_rd(mem_rd_3), .mdr_load(mdr_load_3),
    .mask_ct(mask_ct_3), .mask_out(mask_out_3), .wb_en(wb_en_3), .wb_rd(wb_rd_3),
    .wb_data(wb_data_3), .done(done_3), .err(err_3), .busy(busy_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load on the MEM_LAT=1 instance, starting in an IDLE cycle and ending in
  // the IDLE cycle after WB. With hold set, req_valid stays high with other fields.
  task automatic run_load(input string name, input logic [1:0] t, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] exp_data, input bit hold);
    logic [6:0] exp;
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_rd    = rd;
    tick();
    if (hold) begin
      req_type = 2'd1;
      req_addr = 32'hFFFC;
      req_rd   = 5'd31;
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 1; c <= 5; c++) begin
      exp = {c == 1, c == 2, c == 4, c == 4, 1'b0, c <= 4, c == 5};
      checks++;
      if (ctrl_1 !== exp) begin
        failures++;
        $display("FAIL %s ctrl cycle %0d: got %b want %b", name, c, ctrl_1, exp);
      end
      checks++;
      if ({mem_addr_1, mask_ct_1, wb_rd_1} !== {a, t, rd}) begin
        failures++;
        $display("FAIL %s held fields cycle %0d: got addr=%h ct=%0d rd=%0d want addr=%h ct=%0d rd=%0d",
                 name, c, mem_addr_1, mask_ct_1, wb_rd_1, a, t, rd);
      end
      if (c == 4) begin
        checks++;
        if (wb_data_1 !== exp_data) begin
          failures++;
          $display("FAIL %s wb_data: got %h want %h", name, wb_data_1, exp_data);
        end
      end
      if (c < 5) tick();
    end
    exp_done_1++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (ctrl_1 !== 7'b0000001 || ctrl_3 !== 7'b0000001) begin
      failures++;
      $display("FAIL reset ctrl: got %b/%b want 0000001", ctrl_1, ctrl_3);
    end
    checks++;
    if ({mem_addr_1, wb_data_1, mask_ct_1, wb_rd_1} !== '0 ||
        {mem_addr_3, wb_data_3, mask_ct_3, wb_rd_3} !== '0) begin
      failures++;
      $display("FAIL reset data: got addr=%h wb=%h ct=%0d rd=%0d want all zero",
               mem_addr_1, wb_data_1, mask_ct_1, wb_rd_1);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ctrl_1 !== 7'b0000001) begin
      failures++;
      $display("FAIL reset release ctrl: got %b want 0000001", ctrl_1);
    end
  endtask

  task automatic test_lw();
    run_load("lw", 2'd0, 32'h10, 5'd5, 32'h8001F0F5, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_load("lh", 2'd1, 32'h10, 5'd6, 32'h0000F0F5, 1'b0);
    run_load("lb", 2'd2, 32'h10, 5'd7, 32'h000000F5, 1'b0);
  endtask

  task automatic test_illegal();
    req_valid = 1'b1;
    req_type  = 2'd3;
    req_addr  = 32'h99;
    req_rd    = 5'd20;
    tick();
    checks++;
    if (ctrl_1 !== 7'b0000101) begin
      failures++;
      $display("FAIL illegal ctrl: got %b want 0000101", ctrl_1);
    end
    checks++;
    if ({mem_addr_1, mask_ct_1, wb_rd_1} !== {32'h10, 2'd2, 5'd7}) begin
      failures++;
      $display("FAIL illegal held fields: got addr=%h ct=%0d rd=%0d want addr=10 ct=2 rd=7",
               mem_addr_1, mask_ct_1, wb_rd_1);
    end
    run_load("lw_after_err", 2'd0, 32'h40, 5'd9, 32'hFFFFFFBF, 1'b0);
  endtask

  task automatic test_hold_valid();
    run_load("lw_hold", 2'd0, 32'h80, 5'd9, 32'hFFFFFF7F, 1'b1);
    run_load("lb_after_hold", 2'd2, 32'h20, 5'd10, 32'h000000DF, 1'b0);
    checks++;
    if (done_cnt_1 !== exp_done_1) begin
      failures++;
      $display("FAIL done count: got %0d want %0d", done_cnt_1, exp_done_1);
    end
  endtask

  task automatic test_reset_mid();
    int d3;
    d3 = done_cnt_3;
    req_valid = 1'b1;
    req_type  = 2'd0;
    req_addr  = 32'h10;
    req_rd    = 5'd3;
    tick();
    req_valid = 1'b0;
    checks++;
    if (ctrl_1 !== 7'b1000010 || ctrl_3 !== 7'b1000010) begin
      failures++;
      $display("FAIL abort pre ctrl: got %b/%b want 1000010", ctrl_1, ctrl_3);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (ctrl_1 !== 7'b0000001 || ctrl_3 !== 7'b0000001) begin
      failures++;
      $display("FAIL abort ctrl: got %b/%b want 0000001", ctrl_1, ctrl_3);
    end
    checks++;
    if ({mem_addr_1, wb_data_1, mask_ct_1, wb_rd_1} !== '0) begin
      failures++;
      $display("FAIL abort data: got addr=%h wb=%h ct=%0d rd=%0d want all zero",
               mem_addr_1, wb_data_1, mask_ct_1, wb_rd_1);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (done_cnt_1 !== exp_done_1 || done_cnt_3 !== d3) begin
      failures++;
      $display("FAIL abort done: got %0d/%0d want %0d/%0d", done_cnt_1, done_cnt_3, exp_done_1, d3);
    end
    run_load("lw_after_reset", 2'd0, 32'h10, 5'd3, 32'h8001F0F5, 1'b0);
  endtask

  task automatic test_lat3();
    logic [6:0] exp;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req_valid = 1'b1;
    req_type  = 2'd1;
    req_addr  = 32'h10;
    req_rd    = 5'd12;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp = {c <= 3, c == 4, c == 6, c == 6, 1'b0, c <= 6, c == 7};
      checks++;
      if (ctrl_3 !== exp) begin
        failures++;
        $display("FAIL lat3 ctrl cycle %0d: got %b want %b", c, ctrl_3, exp);
      end
      if (c == 6) begin
        checks++;
        if ({wb_data_3, wb_rd_3, mask_ct_3} !== {32'h0000F0F5, 5'd12, 2'd1}) begin
          failures++;
          $display("FAIL lat3 wb: got data=%h rd=%0d ct=%0d want data=0000f0f5 rd=12 ct=1",
                   wb_data_3, wb_rd_3, mask_ct_3);
        end
      end
      if (c < 7) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_illegal();
    test_hold_valid();
    test_reset_mid();
    test_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
